// File: rtl/packet_buffer.sv
// Dual-word packet buffer: 64-bit agent accesses over 32-bit storage, with packet length tracking.
// The storage is split into even and odd word banks, so each access touches exactly one word per bank.
module packet_buffer #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH+2*WORD_WIDTH+2-1:0]  from_mux,
    input  logic                                  clear,
    output logic [2*WORD_WIDTH+ADDR_WIDTH-1:0]    to_mux,
    output logic                                  rd_valid,
    output logic                                  len_sat
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int HALF_DEPTH = DEPTH / 2;
    localparam int IW         = ADDR_WIDTH - 1;
    localparam int DW         = 2 * WORD_WIDTH;
    localparam logic [ADDR_WIDTH:0]   MAX_LEN_EXT = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN     = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DW-1:0]         req_data;
    logic                  req_wr;
    logic                  req_rd;

    assign req_addr = from_mux[ADDR_WIDTH+DW+1 -: ADDR_WIDTH];
    assign req_data = from_mux[DW+1 -: DW];
    assign req_wr   = from_mux[1];
    assign req_rd   = from_mux[0];

    // Two-stage release so no access is taken on the first edge after rst_n rises.
    logic [1:0] rst_sync;
    logic       ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign ready = rst_sync[1];

    logic wr_fire;
    logic rd_fire;
    logic clr_fire;

    assign wr_fire  = ready & req_wr;
    assign rd_fire  = ready & req_rd & ~req_wr;
    assign clr_fire = ready & clear;

    // Word addr lives in bank addr[0]; addr+1 in the other bank, wrapping to word 0.
    logic [IW-1:0]         odd_idx;
    logic [IW-1:0]         even_idx;
    logic [WORD_WIDTH-1:0] wr_hi;
    logic [WORD_WIDTH-1:0] wr_lo;
    logic [WORD_WIDTH-1:0] even_wdata;
    logic [WORD_WIDTH-1:0] odd_wdata;

    assign odd_idx    = req_addr[ADDR_WIDTH-1:1];
    assign even_idx   = odd_idx + IW'(req_addr[0]);
    assign wr_hi      = req_data[DW-1:WORD_WIDTH];
    assign wr_lo      = req_data[WORD_WIDTH-1:0];
    assign even_wdata = req_addr[0] ? wr_lo : wr_hi;
    assign odd_wdata  = req_addr[0] ? wr_hi : wr_lo;

    logic [WORD_WIDTH-1:0] bank_even [HALF_DEPTH];
    logic [WORD_WIDTH-1:0] bank_odd  [HALF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_even[even_idx] <= even_wdata;
            bank_odd[odd_idx]   <= odd_wdata;
        end
    end

    // rd_valid is a one-cycle strobe with no backpressure: it is high exactly in the
    // cycle after an accepted read, and rd_data holds until the next accepted read.
    logic [DW-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= req_addr[0] ? {bank_odd[odd_idx], bank_even[even_idx]}
                                       : {bank_even[even_idx], bank_odd[odd_idx]};
            end
        end
    end

    logic [ADDR_WIDTH:0]   cand_ext;
    logic                  cand_sat;
    logic [ADDR_WIDTH-1:0] cand_len;
    logic [ADDR_WIDTH-1:0] packet_len;
    logic [ADDR_WIDTH-1:0] len_next;
    logic                  sat_next;

    assign cand_ext = {1'b0, req_addr} + (ADDR_WIDTH+1)'(2);
    assign cand_sat = cand_ext > MAX_LEN_EXT;
    assign cand_len = cand_sat ? MAX_LEN : cand_ext[ADDR_WIDTH-1:0];

    // A write in the clear cycle starts the new packet rather than extending the old one.
    always_comb begin
        len_next = packet_len;
        sat_next = len_sat;
        if (clr_fire) begin
            len_next = '0;
            sat_next = 1'b0;
            if (wr_fire) begin
                len_next = cand_len;
                sat_next = cand_sat;
            end
        end else if (wr_fire) begin
            if (cand_len > packet_len) begin
                len_next = cand_len;
            end
            sat_next = len_sat | cand_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packet_len <= '0;
            len_sat    <= 1'b0;
        end else begin
            packet_len <= len_next;
            len_sat    <= sat_next;
        end
    end

    assign to_mux = {rd_data, packet_len};

endmodule

// File: tb/tb_packet_buffer.sv
// Directed bench for packet_buffer: hand-computed expectations for reads, length tracking,
// wrap-around, clear interactions and asynchronous reset.
module tb_packet_buffer;

    logic        clk;
    logic        rst_n;
    logic [75:0] from_mux;
    logic        clear;
    logic [73:0] to_mux;
    logic        rd_valid;
    logic        len_sat;

    int checks;
    int errors;

    packet_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .from_mux (from_mux),
        .clear    (clear),
        .to_mux   (to_mux),
        .rd_valid (rd_valid),
        .len_sat  (len_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and sampled on the next one.
    task automatic drive(input logic [9:0] a, input logic [63:0] d,
                         input logic we, input logic re, input logic clr);
        from_mux = {a, d, we, re};
        clear    = clr;
        @(posedge clk);
        #1;
        from_mux = '0;
        clear    = 1'b0;
    endtask

    task automatic idle();
        drive(10'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rd_data();
        return to_mux[73:10];
    endfunction

    function automatic logic [63:0] plen();
        return {54'd0, to_mux[9:0]};
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        from_mux = '0;
        clear    = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_to_mux", {to_mux[73:10] | {54'd0, to_mux[9:0]}}, 64'd0);
        check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("reset_len_sat", {63'd0, len_sat}, 64'd0);

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // Write on the first edge after release must be ignored.
        drive(10'd100, 64'h0123_0123_0123_0123, 1'b1, 1'b0, 1'b0);
        check("sync_first_edge_len", plen(), 64'd0);
        repeat (3) idle();

        // Basic write then read
        drive(10'd0, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0);
        check("w0_len", plen(), 64'd2);
        drive(10'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r0_valid", {63'd0, rd_valid}, 64'd1);
        check("r0_data", rd_data(), 64'h1111_2222_3333_4444);
        check("r0_len", plen(), 64'd2);
        idle();
        check("idle_valid", {63'd0, rd_valid}, 64'd0);
        check("idle_hold", rd_data(), 64'h1111_2222_3333_4444);

        // Writes at 2 and 4, read straddling words 1 and 2
        drive(10'd2, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 1'b0);
        drive(10'd4, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b0, 1'b0);
        check("w4_len", plen(), 64'd6);
        drive(10'd1, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r1_data", rd_data(), 64'h3333_4444_5555_6666);
        check("r1_len", plen(), 64'd6);

        // Wrap-around write at the top word saturates the length
        drive(10'd1023, 64'hAAAA_0000_BBBB_1111, 1'b1, 1'b0, 1'b0);
        check("w1023_len", plen(), 64'd1023);
        check("w1023_sat", {63'd0, len_sat}, 64'd1);
        drive(10'd1023, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r1023_data", rd_data(), 64'hAAAA_0000_BBBB_1111);
        drive(10'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r0_wrapped", rd_data(), 64'hBBBB_1111_3333_4444);

        // Length never decreases
        drive(10'd4, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b0, 1'b0);
        check("nodec_len", plen(), 64'd1023);
        check("nodec_sat", {63'd0, len_sat}, 64'd1);

        // Clear alone
        drive(10'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        check("clr_len", plen(), 64'd0);
        check("clr_sat", {63'd0, len_sat}, 64'd0);
        check("clr_hold", rd_data(), 64'hBBBB_1111_3333_4444);

        // Write and read together: write wins, no read result
        drive(10'd5, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0);
        check("wr_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("wr_rd_hold", rd_data(), 64'hBBBB_1111_3333_4444);
        check("wr_rd_len", plen(), 64'd7);
        drive(10'd5, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r5_valid", {63'd0, rd_valid}, 64'd1);
        check("r5_data", rd_data(), 64'h0123_4567_89AB_CDEF);

        // Clear combined with write
        drive(10'd8, 64'h0000_0008_0000_0009, 1'b1, 1'b0, 1'b0);
        check("w8_len", plen(), 64'd10);
        drive(10'd2, 64'hCAFE_F00D_DEAD_BEEF, 1'b1, 1'b0, 1'b1);
        check("clrw2_len", plen(), 64'd4);
        check("clrw2_sat", {63'd0, len_sat}, 64'd0);
        drive(10'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        check("clr2_len", plen(), 64'd0);
        drive(10'd1022, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 1'b1);
        check("clrw1022_len", plen(), 64'd1023);
        check("clrw1022_sat", {63'd0, len_sat}, 64'd1);
        drive(10'd11, 64'h0000_000C_0000_000D, 1'b1, 1'b0, 1'b1);
        check("clrw11_len", plen(), 64'd13);
        check("clrw11_sat", {63'd0, len_sat}, 64'd0);

        // Clear combined with read
        drive(10'd4, 64'd0, 1'b0, 1'b1, 1'b1);
        check("clrr4_valid", {63'd0, rd_valid}, 64'd1);
        check("clrr4_data", rd_data(), 64'h9999_AAAA_0123_4567);
        check("clrr4_len", plen(), 64'd0);
        drive(10'd2, 64'd0, 1'b0, 1'b1, 1'b0);
        check("r2_after_clr", rd_data(), 64'hCAFE_F00D_DEAD_BEEF);

        // All-zero bundle is a no-op
        idle();
        check("noop_valid", {63'd0, rd_valid}, 64'd0);
        check("noop_len", plen(), 64'd0);
        check("noop_hold", rd_data(), 64'hCAFE_F00D_DEAD_BEEF);

        // Reset during a read cycle
        drive(10'd1022, 64'h0000_0003_0000_0003, 1'b1, 1'b0, 1'b0);
        check("pre_rst_sat", {63'd0, len_sat}, 64'd1);
        from_mux = {10'd0, 64'd0, 1'b0, 1'b1};
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_data", rd_data(), 64'd0);
        check("rst_len", plen(), 64'd0);
        check("rst_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_sat", {63'd0, len_sat}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_valid_after_edge", {63'd0, rd_valid}, 64'd0);
        from_mux = '0;
        #2 rst_n = 1'b1;
        repeat (3) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_buffer.md
PACKET_BUFFER -- requirements
Module: packet_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the word-address width; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WORD_WIDTH, default 32, is the storage word width; bus data width is 2*WORD_WIDTH (64).
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 from_mux  input  ADDR_WIDTH+2*WORD_WIDTH+2  agent bundle {addr, wr_data, wr_en, rd_en}, MSB first.
REQ-006 clear  input  1  single-cycle pulse from buffer arbiter on ownership handoff; starts a new packet.
REQ-007 to_mux  output  2*WORD_WIDTH+ADDR_WIDTH  response bundle {rd_data, packet_len}, MSB first.
REQ-008 rd_valid  output  1  high for one cycle when rd_data carries the result of the previous cycle's read.
REQ-009 len_sat  output  1  sticky flag: packet_len saturated since last clear.

Function
REQ-010 Storage SHALL be 2**ADDR_WIDTH words of WORD_WIDTH bits; contents are not reset.
REQ-011 Write (wr_en=1): mem[addr] <= wr_data[63:32], mem[(addr+1) mod depth] <= wr_data[31:0], at the same clock edge.
REQ-012 Read (rd_en=1, wr_en=0): rd_data <= {mem[addr], mem[(addr+1) mod depth]}, registered, 1-cycle latency; rd_valid=1 in the following cycle.
REQ-013 rd_data SHALL hold its last value until the next accepted read; rd_valid=0 in all cycles not following an accepted read.
REQ-014 wr_en and rd_en both high: write performed, read ignored, rd_valid=0 next cycle.
REQ-015 Read in cycle N+1 of an address written in cycle N SHALL return the new data (no stale read).
REQ-016 Wrap-around: addr = depth-1 accesses word depth-1 then word 0, for both read and write.
REQ-017 packet_len (ADDR_WIDTH bits) = number of 32-bit words spanned by the packet = max over writes since clear of (addr+2), computed in ADDR_WIDTH+1 bits.
REQ-018 If addr+2 > 2**ADDR_WIDTH-1, packet_len SHALL saturate at 2**ADDR_WIDTH-1 and len_sat SHALL set.
REQ-019 packet_len updates at the write edge; visible on to_mux the cycle after the write.
REQ-020 packet_len SHALL never decrease except on clear or reset.
REQ-021 clear alone: packet_len <= 0, len_sat <= 0 next cycle; memory untouched; in-flight read still completes with rd_valid.
REQ-022 clear with write same cycle: write performed, packet_len <= addr+2 (saturation rule applies), len_sat from this write only.
REQ-023 clear with read same cycle: read performed normally; packet_len <= 0.
REQ-024 from_mux all-zero (unselected, mux drives 0) SHALL be a no-op.

Reset
REQ-025 rst_n low SHALL asynchronously force rd_data=0, packet_len=0, rd_valid=0, len_sat=0.
REQ-026 Reset deasserted SHALL be synchronized internally so the first access is accepted no earlier than the second rising edge after rst_n rises.
REQ-027 Reset asserted mid-read SHALL suppress rd_valid for that read; memory contents undefined-but-unchanged by reset.

Verification
REQ-028 Write addr=0 data 0x11112222_33334444, next cycle read addr=0 -> cycle after: rd_valid=1, rd_data=0x11112222_33334444, packet_len=2.
REQ-029 Writes at addr 0,2,4 then read addr=1 -> packet_len=6, rd_data={0x33334444-word-1 value, word-2 upper half} matches model.
REQ-030 Write addr=1023 data 0xAAAA0000_BBBB1111 -> mem[1023]=0xAAAA0000, mem[0]=0xBBBB1111; packet_len=1023, len_sat=1.
REQ-031 wr_en=rd_en=1 at addr 5 -> memory written, rd_valid=0, rd_data unchanged.
REQ-032 Write addr=8 (len=10), then clear+write addr=2 same cycle -> packet_len=4, len_sat=0; clear alone next -> packet_len=0.
REQ-033 Assert rst_n low during read cycle -> rd_valid stays 0, rd_data=0, packet_len=0 immediately, no clock required.
